aluctrl_encoder: RTL

Inverse of the ALU-control decode path. It accepts a 4-bit ALU operation code plus an R/I instruction-type select and produces the matching RV32I field triple. The triple is `aluop` (opcode[6:2]), `funct3`, and `funct7[5]`, delivered over a valid/ready handshake. A tick-driven sweep mode steps through every legal encoding, so the board can drive the decode path and 7-segment display without switches.

---
 rtl/aluctrl_encoder.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/aluctrl_encoder.sv
// aluctrl_encoder: maps a 4-bit ALU operation code and an R/I type select onto
// the RV32I field triple {opcode[6:2], funct3, funct7[5]}. Results leave over a
// valid/ready handshake. A tick-driven sweep mode walks through every legal
// encoding so a board can exercise the decode path without switches.
module aluctrl_encoder (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [3:0] req_op_i,
    input  logic       req_imm_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic [4:0] aluop_o,
    output logic [2:0] f3_o,
    output logic       f7_o,
    output logic       err_o,
    output logic [3:0] idx_o,
    input  logic       sweep_en_i,
    input  logic       sweep_imm_i,
    input  logic       tick_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HOLD  = 2'd1,
        S_SWEEP = 2'd2
    } state_t;

    typedef struct packed {
        logic       err;
        logic [4:0] aluop;
        logic [2:0] f3;
        logic       f7;
    } enc_t;

    localparam logic [4:0] ALUOP_R = 5'b01100;
    localparam logic [4:0] ALUOP_I = 5'b00100;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_LAST = 4'd9;

    // Field lookup shared by the request path and the sweep path. Illegal
    // combinations report err and force all fields to zero.
    function automatic enc_t encode(input logic [3:0] op, input logic imm);
        enc_t       e;
        logic [2:0] f3;
        logic       f7;
        logic       bad;
        f3  = 3'b000;
        f7  = 1'b0;
        bad = 1'b0;
        case (op)
            4'd0: f3 = 3'b000;
            4'd1: begin
                f3  = 3'b000;
                f7  = 1'b1;
                bad = imm;          // there is no SUBI
            end
            4'd2: f3 = 3'b001;
            4'd3: f3 = 3'b010;
            4'd4: f3 = 3'b011;
            4'd5: f3 = 3'b100;
            4'd6: f3 = 3'b101;
            4'd7: begin
                f3 = 3'b101;
                f7 = 1'b1;          // SRA/SRAI both carry funct7[5]
            end
            4'd8: f3 = 3'b110;
            4'd9: f3 = 3'b111;
            default: bad = 1'b1;
        endcase
        e.err = bad;
        if (bad) begin
            e.aluop = 5'b00000;
            e.f3    = 3'b000;
            e.f7    = 1'b0;
        end else begin
            e.aluop = imm ? ALUOP_I : ALUOP_R;
            e.f3    = f3;
            e.f7    = f7;
        end
        return e;
    endfunction

    state_t     r_state, w_state_next;
    logic       r_out_valid, w_out_valid_next;
    logic [4:0] r_aluop, w_aluop_next;
    logic [2:0] r_f3, w_f3_next;
    logic       r_f7, w_f7_next;
    logic       r_err, w_err_next;
    logic [3:0] r_idx, w_idx_next;
    logic       r_sweep_imm, w_sweep_imm_next;

    logic [3:0] w_sweep_idx;
    enc_t       w_req_enc;
    enc_t       w_entry_enc;
    enc_t       w_sweep_enc;

    // Next sweep position: 0..9 with wrap; SUB is skipped for I-type sweeps.
    always_comb begin
        w_sweep_idx = (r_idx >= OP_LAST) ? 4'd0 : r_idx + 4'd1;
        if (r_sweep_imm && (w_sweep_idx == OP_SUB)) begin
            w_sweep_idx = 4'd2;
        end
    end

    assign w_req_enc   = encode(req_op_i, req_imm_i);
    assign w_entry_enc = encode(4'd0, sweep_imm_i);
    assign w_sweep_enc = encode(w_sweep_idx, r_sweep_imm);

    // Only IDLE accepts requests, and a pending sweep entry blocks acceptance.
    assign req_ready_o = (r_state == S_IDLE) && !sweep_en_i;

    // Next-state and next-output decisions; fields hold unless overwritten.
    always_comb begin
        w_state_next     = r_state;
        w_out_valid_next = 1'b0;
        w_aluop_next     = r_aluop;
        w_f3_next        = r_f3;
        w_f7_next        = r_f7;
        w_err_next       = r_err;
        w_idx_next       = r_idx;
        w_sweep_imm_next = r_sweep_imm;
        case (r_state)
            S_IDLE: begin
                if (sweep_en_i) begin
                    // Sweep entry beats a simultaneous request.
                    w_state_next     = S_SWEEP;
                    w_sweep_imm_next = sweep_imm_i;
                    w_idx_next       = 4'd0;
                    w_aluop_next     = w_entry_enc.aluop;
                    w_f3_next        = w_entry_enc.f3;
                    w_f7_next        = w_entry_enc.f7;
                    w_err_next       = 1'b0;
                    w_out_valid_next = 1'b1;
                end else if (req_valid_i) begin
                    w_state_next     = S_HOLD;
                    w_idx_next       = req_op_i;
                    w_aluop_next     = w_req_enc.aluop;
                    w_f3_next        = w_req_enc.f3;
                    w_f7_next        = w_req_enc.f7;
                    w_err_next       = w_req_enc.err;
                    w_out_valid_next = 1'b1;
                end
            end
            S_HOLD: begin
                w_out_valid_next = 1'b1;
                if (out_ready_i) begin
                    w_state_next     = S_IDLE;
                    w_out_valid_next = 1'b0;
                end
            end
            S_SWEEP: begin
                if (!sweep_en_i) begin
                    // Exit wins over a coincident tick.
                    w_state_next = S_IDLE;
                end else if (tick_i) begin
                    w_idx_next       = w_sweep_idx;
                    w_aluop_next     = w_sweep_enc.aluop;
                    w_f3_next        = w_sweep_enc.f3;
                    w_f7_next        = w_sweep_enc.f7;
                    w_err_next       = 1'b0;
                    w_out_valid_next = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any un-acknowledged output.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_aluop     <= 5'b00000;
            r_f3        <= 3'b000;
            r_f7        <= 1'b0;
            r_err       <= 1'b0;
            r_idx       <= 4'd0;
            r_sweep_imm <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_out_valid <= w_out_valid_next;
            r_aluop     <= w_aluop_next;
            r_f3        <= w_f3_next;
            r_f7        <= w_f7_next;
            r_err       <= w_err_next;
            r_idx       <= w_idx_next;
            r_sweep_imm <= w_sweep_imm_next;
        end
    end

    assign out_valid_o = r_out_valid;
    assign aluop_o     = r_aluop;
    assign f3_o        = r_f3;
    assign f7_o        = r_f7;
    assign err_o       = r_err;
    assign idx_o       = r_idx;

endmodule
